code_sender: RTL and testbench
==============================

CODE_SENDER -- requirements
Module: code_sender

Interface
REQ-001 Parameter NDIG, default 6, number of digits per code.
REQ-002 Parameter GAP, default 2, idle cycles inserted between accepted digits (0 = back-to-back).
REQ-003 Parameter RESET_CODE, default 24'h875828, code register value after reset; first digit in the most significant nibble.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 load  input  1  write code_in into the code register.
REQ-007 code_in  input  4*NDIG  new code; first digit in the most significant nibble.
REQ-008 start  input  1  begin transmitting the stored code.
REQ-009 abort  input  1  cancel an in-progress transmission.
REQ-010 digit_ready  input  1  receiver accepts the current digit.
REQ-011 digit  output  4  current digit value.
REQ-012 digit_valid  output  1  digit is presented for transfer.
REQ-013 busy  output  1  transmission in progress.
REQ-014 done  output  1  one-cycle pulse after the last digit is accepted.
REQ-015 sent_count  output  3  number of digits accepted in the current or last transmission.

Function
REQ-016 The FSM SHALL have four states: IDLE, SEND, GAP_WAIT, DONE, all registered.
REQ-017 In IDLE, load SHALL update the code register on the next edge; load in any other state SHALL be ignored.
REQ-018 In IDLE, start SHALL move the FSM to SEND, clear sent_count and digit index, and assert busy from the next cycle.
REQ-019 With load and start together in IDLE, the transmission SHALL send code_in (load takes effect first).
REQ-020 In SEND, digit_valid SHALL be 1 and digit SHALL equal nibble [index] of the code register, where index 0 is the most significant nibble.
REQ-021 Transfer SHALL occur on a cycle with digit_valid and digit_ready both 1; digit SHALL stay stable while valid is high and ready is low.
REQ-022 On each transfer, sent_count and index SHALL increment by 1.
REQ-023 On transfer of the last digit (index NDIG-1), the FSM SHALL go to DONE.
REQ-024 On transfer of any earlier digit, the FSM SHALL go to GAP_WAIT if GAP>0, otherwise stay in SEND and present the next digit in the following cycle.
REQ-025 GAP_WAIT SHALL hold digit_valid 0 for exactly GAP cycles, then return to SEND.
REQ-026 DONE SHALL last exactly one cycle with done=1, busy=0, digit_valid=0, then go to IDLE; start in DONE SHALL be ignored.
REQ-027 abort in SEND or GAP_WAIT SHALL return the FSM to IDLE on the next edge with done not asserted and sent_count holding its value.
REQ-028 abort and a transfer in the same cycle SHALL count the transfer (sent_count increments), then go to IDLE.
REQ-029 start while busy SHALL be ignored.
REQ-030 busy SHALL be 1 exactly in SEND and GAP_WAIT.
REQ-031 digit SHALL be 0 whenever digit_valid is 0.
REQ-032 sent_count SHALL saturate at NDIG and never wrap.
REQ-033 Encountering an illegal state encoding SHALL force IDLE on the next edge.

Reset
REQ-034 Asserting reset (0) SHALL, without waiting for clk, set the state to IDLE, the code register to RESET_CODE, index and sent_count to 0, and digit, digit_valid, busy, done to 0.
REQ-035 Reset asserted mid-transmission SHALL abandon the transmission; no done pulse SHALL follow.
REQ-036 After reset deasserts, the first edge SHALL act on inputs normally.

Verification
REQ-037 Reset, start, digit_ready held 1, GAP=2 -> digits 8,7,5,8,2,8 each valid for 1 cycle, spaced 3 cycles apart; done pulses 1 cycle after the last transfer; sent_count=6.
REQ-038 load 24'h123456 with start in the same cycle, GAP=0, ready=1 -> digits 1,2,3,4,5,6 on consecutive cycles; done on the 7th cycle.
REQ-039 Ready held 0 for 4 cycles on the second digit -> digit holds at 7 with valid=1 for those 4 cycles; no extra increment.
REQ-040 abort asserted after 3 transfers -> idle next cycle, busy=0, done never asserted, sent_count=3.
REQ-041 Async reset pulse mid-gap -> outputs 0 immediately, code back to 875828, no done pulse.
REQ-042 start pulsed while busy, and load pulsed while busy -> transmission unchanged and code register unchanged.

Source files
------------

// File: rtl/code_sender.sv
// Digit-serial code transmitter: streams a stored NDIG-nibble code over a
// valid/ready handshake, MSB nibble first, with an optional idle gap between digits.
module code_sender #(
  parameter int unsigned         NDIG       = 6,
  parameter int unsigned         GAP        = 2,
  parameter logic [4*NDIG-1:0]   RESET_CODE = 24'h875828
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [4*NDIG-1:0]    code_in,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 digit_ready,
  output logic [3:0]           digit,
  output logic                 digit_valid,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           sent_count
);

  localparam int unsigned CODE_W = 4 * NDIG;
  localparam int unsigned IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [2:0]       CNT_MAX  = 3'(NDIG);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e              state_q;
  logic [CODE_W-1:0]   code_q;
  logic [IDX_W-1:0]    idx_q;
  logic [GAP_W-1:0]    gap_q;
  logic [2:0]          cnt_q;
  logic [3:0]          digit_q;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;

  logic [IDX_W-1:0]    idx_inc;
  logic [2:0]          cnt_inc;

  // Nibble i counted from the most significant end of the code word.
  function automatic logic [3:0] nib(input logic [CODE_W-1:0] c,
                                     input logic [IDX_W-1:0]  i);
    logic [CODE_W-1:0] s;
    s = c << {i, 2'b00};
    return s[CODE_W-1 -: 4];
  endfunction

  assign idx_inc = idx_q + IDX_W'(1);
  assign cnt_inc = (cnt_q < CNT_MAX) ? cnt_q + 3'd1 : cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      code_q  <= RESET_CODE;
      idx_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      digit_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) code_q <= code_in;
          // A same-cycle load supplies the code that is transmitted.
          if (start) begin
            state_q <= ST_SEND;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            digit_q <= nib(load ? code_in : code_q, '0);
          end
        end

        ST_SEND: begin
          if (digit_ready) begin
            cnt_q <= cnt_inc;
            idx_q <= idx_inc;
            if (abort || (idx_q == LAST_IDX)) begin
              state_q <= abort ? ST_IDLE : ST_DONE;
              done_q  <= ~abort;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              digit_q <= '0;
            end else if (GAP == 0) begin
              digit_q <= nib(code_q, idx_inc);
            end else begin
              state_q <= ST_GAP;
              gap_q   <= '0;
              valid_q <= 1'b0;
              digit_q <= '0;
            end
          end else if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            digit_q <= '0;
          end
        end

        ST_GAP: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (gap_q == LAST_GAP) begin
            state_q <= ST_SEND;
            valid_q <= 1'b1;
            digit_q <= nib(code_q, idx_q);
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          digit_q <= '0;
        end
      endcase
    end
  end

  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sent_count  = cnt_q;

endmodule

// File: tb/tb_code_sender.sv
// Scoreboard bench for code_sender: directed stimulus pushes expected digits,
// negedge monitors pop them on each handshake and check output invariants.
module tb_code_sender;

  logic        clk;
  logic        rst_n;

  logic        load, start, abort, ready;
  logic [23:0] code_in;
  logic [3:0]  digit;
  logic        valid, busy, done;
  logic [2:0]  sent_count;

  logic        load0, start0, abort0, ready0;
  logic [23:0] code_in0;
  logic [3:0]  digit0;
  logic        valid0, busy0, done0;
  logic [2:0]  sent_count0;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  int q[$];
  int q0[$];

  code_sender #(.NDIG(6), .GAP(2), .RESET_CODE(24'h875828)) u_dut (
    .clk(clk), .reset(rst_n), .load(load), .code_in(code_in), .start(start),
    .abort(abort), .digit_ready(ready), .digit(digit), .digit_valid(valid),
    .busy(busy), .done(done), .sent_count(sent_count)
  );

  code_sender #(.NDIG(6), .GAP(0), .RESET_CODE(24'h875828)) u_dut0 (
    .clk(clk), .reset(rst_n), .load(load0), .code_in(code_in0), .start(start0),
    .abort(abort0), .digit_ready(ready0), .digit(digit0), .digit_valid(valid0),
    .busy(busy0), .done(done0), .sent_count(sent_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_default();
    q.push_back(8); q.push_back(7); q.push_back(5);
    q.push_back(8); q.push_back(2); q.push_back(8);
  endtask

  task automatic wait_done(input string name, input int max);
    int n;
    n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    chk(name, int'(done), 1);
    tick();
  endtask

  // Monitor for the GAP=2 instance.
  logic       stall_q = 1'b0;
  logic [3:0] stall_d = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_extra: digit %0h transferred, none expected", digit);
        end else begin
          chk("sb_digit", int'(digit), q.pop_front());
        end
      end
      if (!valid) chk("digit_zero_when_invalid", int'(digit), 0);
      if (stall_q && valid) chk("digit_stable_in_stall", int'(digit), int'(stall_d));
      stall_q = valid && !ready;
      stall_d = digit;
      if (done) done_cnt++;
    end else begin
      stall_q = 1'b0;
    end
  end

  // Monitor for the GAP=0 instance.
  always @(negedge clk) begin
    if (rst_n && valid0 && ready0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb0_extra: digit %0h transferred, none expected", digit0);
      end else begin
        chk("sb0_digit", int'(digit0), q0.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt, done_at, dc, c;
    rst_n = 1'b1;
    {load, start, abort, ready} = '0;
    {load0, start0, abort0, ready0} = '0;
    code_in = '0;
    code_in0 = '0;

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_digit", int'(digit), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(sent_count), 0);
    chk("rst_valid0", int'(valid0), 0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset code, GAP=2, ready held high.
    ready = 1'b1;
    push_default();
    start = 1'b1;
    tick();
    start = 1'b0;
    vcnt = 0;
    done_at = -1;
    for (int i = 0; i < 20; i++) begin
      if (valid) begin
        chk("t1_valid_cycle", i, 3 * vcnt);
        vcnt++;
      end
      if (done && done_at < 0) begin
        done_at = i;
        chk("t1_busy_in_done", int'(busy), 0);
      end
      tick();
    end
    chk("t1_nvalid", vcnt, 6);
    chk("t1_done_at", done_at, 16);
    chk("t1_count", int'(sent_count), 6);
    chk("t1_done_one_cycle", done_cnt, 1);

    // Load+start together, GAP=0, back-to-back digits.
    ready0 = 1'b1;
    load0 = 1'b1;
    code_in0 = 24'h123456;
    start0 = 1'b1;
    for (int d = 1; d <= 6; d++) q0.push_back(d);
    tick();
    load0 = 1'b0;
    start0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t2_valid", int'(valid0), 1);
      tick();
    end
    chk("t2_done", int'(done0), 1);
    chk("t2_busy", int'(busy0), 0);
    chk("t2_count", int'(sent_count0), 6);
    tick();
    chk("t2_done_cleared", int'(done0), 0);

    // Receiver stalls four cycles on the second digit.
    push_default();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    ready = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t3_stall_valid", int'(valid), 1);
      chk("t3_stall_digit", int'(digit), 7);
      chk("t3_stall_count", int'(sent_count), 1);
      tick();
    end
    ready = 1'b1;
    wait_done("t3_done", 40);
    chk("t3_count", int'(sent_count), 6);

    // Abort in the gap after three transfers.
    q.push_back(8); q.push_back(7); q.push_back(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("t4_count_before_abort", int'(sent_count), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_busy", int'(busy), 0);
    chk("t4_valid", int'(valid), 0);
    chk("t4_count", int'(sent_count), 3);
    dc = done_cnt;
    repeat (8) tick();
    chk("t4_no_done", done_cnt, dc);

    // Abort coinciding with a transfer counts that transfer.
    q.push_back(8);
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4b_count", int'(sent_count), 1);
    chk("t4b_busy", int'(busy), 0);
    repeat (3) tick();

    // Async reset in the gap discards a loaded code and the transmission.
    load = 1'b1;
    code_in = 24'hABCDEF;
    tick();
    load = 1'b0;
    q.push_back(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", int'(valid), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_digit", int'(digit), 0);
    chk("t5_count", int'(sent_count), 0);
    chk("t5_done", int'(done), 0);
    tick();
    rst_n = 1'b1;
    dc = done_cnt;
    repeat (6) tick();
    chk("t5_no_done", done_cnt, dc);
    push_default();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_first_digit", int'(digit), 8);
    wait_done("t5_done_after", 40);

    // start/load while busy and start in DONE are ignored.
    push_default();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    load = 1'b1;
    code_in = 24'h111111;
    tick();
    start = 1'b0;
    load = 1'b0;
    tick();
    chk("t6_digit2", int'(digit), 7);
    start = 1'b1;
    load = 1'b1;
    tick();
    start = 1'b0;
    load = 1'b0;
    chk("t6_count", int'(sent_count), 2);
    c = 4;
    while (!done && c < 40) begin
      tick();
      c++;
    end
    chk("t6_done_at", c, 16);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_start_in_done_valid", int'(valid), 0);
    chk("t6_start_in_done_busy", int'(busy), 0);
    push_default();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_code_kept", int'(digit), 8);
    wait_done("t6_done_again", 40);
    chk("t6_final_count", int'(sent_count), 6);

    repeat (2) tick();
    chk("sb_drained", q.size(), 0);
    chk("sb0_drained", q0.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
